// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Purpose  : HI/LO multiply-divide unit with fixed-latency multiply and divide.
//            Define MD_UNIT_MADD_EN to build MADD/MADDU/MSUB/MSUBU (Ops 8-11).
// Revision : 1.0 - initial release
// ============================================================================
module md_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Busy,
    output logic             Stall,
    output logic [WIDTH-1:0] Result
);
    localparam int c_max_lat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int c_cnt_w   = $clog2(c_max_lat) + 1;

    localparam logic [c_cnt_w-1:0] c_mul_cnt = c_cnt_w'(MUL_LAT);
    localparam logic [c_cnt_w-1:0] c_div_cnt = c_cnt_w'(DIV_LAT);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    localparam logic [3:0] c_op_mult  = 4'd0;
    localparam logic [3:0] c_op_multu = 4'd1;
    localparam logic [3:0] c_op_div   = 4'd2;
    localparam logic [3:0] c_op_divu  = 4'd3;
    localparam logic [3:0] c_op_mfhi  = 4'd4;
    localparam logic [3:0] c_op_mflo  = 4'd5;
    localparam logic [3:0] c_op_mthi  = 4'd6;
    localparam logic [3:0] c_op_mtlo  = 4'd7;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_is_madd;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_run_div;
    logic               w_mul_signed;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_mul_res;

    logic               w_div_signed;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_div_b;
    logic [WIDTH-1:0]   w_uq;
    logic [WIDTH-1:0]   w_ur;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;

`ifdef MD_UNIT_MADD_EN
    localparam logic [3:0] c_op_madd  = 4'd8;
    localparam logic [3:0] c_op_maddu = 4'd9;
    localparam logic [3:0] c_op_msub  = 4'd10;
    localparam logic [3:0] c_op_msubu = 4'd11;

    logic [2*WIDTH-1:0] w_hilo;

    assign w_is_madd    = (Op == c_op_madd) || (Op == c_op_maddu) ||
                          (Op == c_op_msub) || (Op == c_op_msubu);
    assign w_mul_signed = (r_op == c_op_mult) || (r_op == c_op_madd) || (r_op == c_op_msub);
    assign w_hilo       = {r_hi, r_lo};

    always_comb begin
        w_mul_res = w_prod;
        case (r_op)
            c_op_madd, c_op_maddu: w_mul_res = w_hilo + w_prod;
            c_op_msub, c_op_msubu: w_mul_res = w_hilo - w_prod;
            default:               w_mul_res = w_prod;
        endcase
    end
`else
    assign w_is_madd    = 1'b0;
    assign w_mul_signed = (r_op == c_op_mult);
    assign w_mul_res    = w_prod;
`endif

    assign w_is_mul  = (Op == c_op_mult) || (Op == c_op_multu) || w_is_madd;
    assign w_is_div  = (Op == c_op_div) || (Op == c_op_divu);
    assign w_run_div = (r_op == c_op_div) || (r_op == c_op_divu);

    // Operands are extended to 2*WIDTH so one truncated multiply serves both signednesses.
    assign w_a_ext = w_mul_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    assign w_b_ext = w_mul_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    // Magnitude divide; most-negative / -1 falls out naturally as (most-negative, 0).
    assign w_div_signed = (r_op == c_op_div);
    assign w_neg_a      = w_div_signed & r_a[WIDTH-1];
    assign w_neg_b      = w_div_signed & r_b[WIDTH-1];
    assign w_abs_a      = w_neg_a ? (~r_a + 1'b1) : r_a;
    assign w_abs_b      = w_neg_b ? (~r_b + 1'b1) : r_b;
    assign w_div_b      = (w_abs_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_abs_b;
    assign w_uq         = w_abs_a / w_div_b;
    assign w_ur         = w_abs_a % w_div_b;
    assign w_q          = (w_neg_a ^ w_neg_b) ? (~w_uq + 1'b1) : w_uq;
    assign w_r          = w_neg_a ? (~w_ur + 1'b1) : w_ur;

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start && !Flush) begin
                        if (w_is_mul || w_is_div) begin
                            r_op    <= Op;
                            r_a     <= A;
                            r_b     <= B;
                            r_cnt   <= w_is_div ? c_div_cnt : c_mul_cnt;
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end else if (Op == c_op_mthi) begin
                            r_hi <= A;
                        end else if (Op == c_op_mtlo) begin
                            r_lo <= A;
                        end
                    end
                end
                S_RUN: begin
                    if (Flush) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == c_cnt_one) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            if (w_run_div) begin
                                if (r_b != '0) begin
                                    r_hi <= w_r;
                                    r_lo <= w_q;
                                end
                            end else begin
                                r_hi <= w_mul_res[2*WIDTH-1:WIDTH];
                                r_lo <= w_mul_res[WIDTH-1:0];
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy   = r_busy;
    assign Stall  = r_busy | (Start & (w_is_mul | w_is_div));
    assign Result = (Op == c_op_mfhi) ? r_hi :
                    (Op == c_op_mflo) ? r_lo : '0;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit
// Purpose  : Self-checking bench for md_unit: directed cases plus random traffic
//            against an arithmetic reference model of HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_unit;
    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        CLK   = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic        Flush = 1'b0;
    logic [3:0]  Op    = 4'd0;
    logic [31:0] A     = '0;
    logic [31:0] B     = '0;
    logic        Busy;
    logic        Stall;
    logic [31:0] Result;

    md_unit #(
        .WIDTH  (WIDTH),
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .Start (Start),
        .Op    (Op),
        .A     (A),
        .B     (B),
        .Flush (Flush),
        .Busy  (Busy),
        .Stall (Stall),
        .Result(Result)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    // Reference state: architectural HI/LO plus cycles left on the pending op.
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;
    logic [31:0] m_a   = '0;
    logic [31:0] m_b   = '0;
    logic [3:0]  m_op  = '0;
    int          m_rem = 0;

    string       lit_name = "";
    logic [31:0] lit_act  = '0;
    logic [31:0] lit_exp  = '0;
    int          lit_seq  = 0;
    int          lit_done = 0;

    function automatic bit is_long(input logic [3:0] op);
        if (op <= 4'd3) return 1'b1;
`ifdef MD_UNIT_MADD_EN
        if (op >= 4'd8 && op <= 4'd11) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic void model_commit();
        int              sa, sb;
        longint          ps;
        longint unsigned pu, acc;
        sa  = m_a;
        sb  = m_b;
        ps  = longint'(sa) * longint'(sb);
        pu  = longint'(m_a) * longint'(m_b);
        acc = {m_hi, m_lo};
        case (m_op)
            4'd0:  {m_hi, m_lo} = ps;
            4'd1:  {m_hi, m_lo} = pu;
            4'd8:  {m_hi, m_lo} = acc + ps;
            4'd9:  {m_hi, m_lo} = acc + pu;
            4'd10: {m_hi, m_lo} = acc - ps;
            4'd11: {m_hi, m_lo} = acc - pu;
            4'd2: begin
                if (m_b != 0) begin
                    if (m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF) begin
                        m_lo = m_a;
                        m_hi = '0;
                    end else begin
                        m_lo = sa / sb;
                        m_hi = sa % sb;
                    end
                end
            end
            4'd3: begin
                if (m_b != 0) begin
                    m_lo = m_a / m_b;
                    m_hi = m_a % m_b;
                end
            end
            default: ;
        endcase
    endfunction

    always @(posedge CLK) begin
        if (!Reset) begin
            m_hi  = '0;
            m_lo  = '0;
            m_rem = 0;
        end else if (m_rem > 0) begin
            if (Flush) begin
                m_rem = 0;
            end else begin
                m_rem = m_rem - 1;
                if (m_rem == 0) model_commit();
            end
        end else if (Start && !Flush) begin
            if (is_long(Op)) begin
                m_op  = Op;
                m_a   = A;
                m_b   = B;
                m_rem = (Op == 4'd2 || Op == 4'd3) ? DIV_LAT : MUL_LAT;
            end else if (Op == 4'd6) begin
                m_hi = A;
            end else if (Op == 4'd7) begin
                m_lo = A;
            end
        end
    end

    // Single checker: literal expectations posted by the stimulus, then the model compare.
    always @(negedge CLK) begin
        logic        e_busy, e_stall;
        logic [31:0] e_res;
        if (lit_seq != lit_done) begin
            total++;
            if (lit_act !== lit_exp) begin
                bad++;
                $display("FAIL %s: got %h expected %h", lit_name, lit_act, lit_exp);
            end
            lit_done = lit_seq;
        end
        if (checking) begin
            e_busy  = (m_rem > 0);
            e_stall = e_busy | (Start & is_long(Op));
            e_res   = (Op == 4'd4) ? m_hi : (Op == 4'd5) ? m_lo : 32'h0;
            total++;
            if (Busy !== e_busy || Stall !== e_stall || Result !== e_res) begin
                bad++;
                $display("FAIL model t=%0t op=%0d: busy/stall/result got %b/%b/%h expected %b/%b/%h",
                         $time, Op, Busy, Stall, Result, e_busy, e_stall, e_res);
            end
        end
    end

    task automatic drive(input bit st, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit fl = 1'b0);
        @(posedge CLK);
        #1;
        Start = st;
        Op    = op;
        A     = a;
        B     = b;
        Flush = fl;
    endtask

    task automatic read(input logic [3:0] op, output logic [31:0] r);
        drive(1'b0, op, 32'h0, 32'h0);
        #1;
        r = Result;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        lit_name = name;
        lit_act  = act;
        lit_exp  = exp;
        lit_seq++;
        @(negedge CLK);
        #1;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (Busy) n++;
            else break;
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] r;
        int          n;

        repeat (3) @(posedge CLK);
        #1;
        Reset    = 1'b1;
        checking = 1'b1;

        read(4'd4, r); lit("reset_hi", r, 32'h0);
        read(4'd5, r); lit("reset_lo", r, 32'h0);
        lit("reset_busy", 32'(Busy), 32'h0);

        drive(1'b1, 4'd0, 32'hFFFF_FFFE, 32'd3);
        drive(1'b0, 4'd4, 32'h0, 32'h0);
        busy_len(n); lit("mult_busy_len", n, 32'd5);
        read(4'd4, r); lit("mult_hi", r, 32'hFFFF_FFFF);
        read(4'd5, r); lit("mult_lo", r, 32'hFFFF_FFFA);

        drive(1'b1, 4'd2, 32'hFFFF_FFF9, 32'd2);
        drive(1'b0, 4'd4, 32'h0, 32'h0);
        busy_len(n); lit("div_busy_len", n, 32'd10);
        read(4'd5, r); lit("div_lo", r, 32'hFFFF_FFFD);
        read(4'd4, r); lit("div_hi", r, 32'hFFFF_FFFF);

        drive(1'b1, 4'd3, 32'd7, 32'd0);
        drive(1'b0, 4'd4, 32'h0, 32'h0);
        busy_len(n); lit("divu0_busy_len", n, 32'd10);
        read(4'd4, r); lit("divu0_hi", r, 32'hFFFF_FFFF);
        read(4'd5, r); lit("divu0_lo", r, 32'hFFFF_FFFD);

        drive(1'b1, 4'd7, 32'h1234_5678, 32'h0);
        read(4'd5, r); lit("mtlo_mflo", r, 32'h1234_5678);
        lit("mtlo_busy", 32'(Busy), 32'h0);

        drive(1'b1, 4'd3, 32'd100, 32'd7);
        drive(1'b1, 4'd0, 32'd5, 32'd5);
        drive(1'b0, 4'd4, 32'h0, 32'h0);
        drive(1'b0, 4'd4, 32'h0, 32'h0);
        drive(1'b0, 4'd4, 32'h0, 32'h0, 1'b1);
        drive(1'b0, 4'd4, 32'h0, 32'h0);
        lit("flush_busy", 32'(Busy), 32'h0);
        busy_len(n); lit("flush_idle_len", n, 32'd0);
        read(4'd4, r); lit("flush_hi", r, 32'hFFFF_FFFF);
        read(4'd5, r); lit("flush_lo", r, 32'h1234_5678);

        drive(1'b1, 4'd0, 32'd3, 32'd4);
        drive(1'b0, 4'd4, 32'h0, 32'h0);
        drive(1'b0, 4'd4, 32'h0, 32'h0);
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        lit("rst_busy", 32'(Busy), 32'h0);
        read(4'd4, r); lit("rst_hi", r, 32'h0);
        read(4'd5, r); lit("rst_lo", r, 32'h0);
        drive(1'b1, 4'd0, 32'd7, 32'd6);
        drive(1'b0, 4'd4, 32'h0, 32'h0);
        busy_len(n); lit("post_rst_busy_len", n, 32'd5);
        read(4'd5, r); lit("post_rst_lo", r, 32'd42);
        read(4'd4, r); lit("post_rst_hi", r, 32'h0);

        drive(1'b1, 4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        drive(1'b0, 4'd4, 32'h0, 32'h0);
        busy_len(n);
        read(4'd5, r); lit("divovf_lo", r, 32'h8000_0000);
        read(4'd4, r); lit("divovf_hi", r, 32'h0);

        drive(1'b1, 4'd6, 32'h0, 32'h0);
        drive(1'b1, 4'd7, 32'hFFFF_FFFF, 32'h0);
        drive(1'b1, 4'd9, 32'd1, 32'd1);
`ifdef MD_UNIT_MADD_EN
        lit("maddu_stall", 32'(Stall), 32'h1);
        drive(1'b0, 4'd4, 32'h0, 32'h0);
        busy_len(n); lit("maddu_busy_len", n, 32'd5);
        read(4'd4, r); lit("maddu_hi", r, 32'h1);
        read(4'd5, r); lit("maddu_lo", r, 32'h0);
`else
        lit("noop_stall", 32'(Stall), 32'h0);
        drive(1'b0, 4'd4, 32'h0, 32'h0);
        busy_len(n); lit("noop_busy_len", n, 32'd0);
        read(4'd4, r); lit("noop_hi", r, 32'h0);
        read(4'd5, r); lit("noop_lo", r, 32'hFFFF_FFFF);
`endif

        for (int i = 0; i < 3000; i++) begin
            @(posedge CLK);
            #1;
            Reset = ($urandom_range(0, 149) != 0);
            Flush = ($urandom_range(0, 29) == 0);
            Start = ($urandom_range(0, 2) == 0);
            Op    = ($urandom_range(0, 4) < 2) ? 4'(4 + $urandom_range(0, 1))
                                               : 4'($urandom_range(0, 15));
            A     = rnd_operand();
            B     = rnd_operand();
        end

        @(posedge CLK);
        #1;
        Reset = 1'b1;
        Flush = 1'b0;
        Start = 1'b0;
        Op    = 4'd4;
        repeat (DIV_LAT + 4) @(posedge CLK);
        #2;
        Op = 4'd5;
        repeat (2) @(posedge CLK);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
